// File: rtl/ccd_pattern_gen.sv
// -----------------------------------------------------------------------------
// ccd_pattern_gen
//
// Synthetic D5M-style sensor source. Produces FVAL/LVAL framing and pixel data
// with the same timing the CCD capture path consumes, so that it can be muxed
// in place of D5M_D/FVAL/LVAL for bring-up and bench tests. The patterns are
// deterministic, so RAW2RGB, the red-pass filter and block_found can be
// exercised without a camera attached.
//
// Frame sequence (one frame):
//   VBLANK : FVAL=0, LVAL=0 for V_BLANK*(H_ACTIVE+H_BLANK) cycles
//   FPORCH : 1 cycle, FVAL=1, LVAL=0; iMODE/iLEVEL captured on entry
//   ACTIVE : H_ACTIVE cycles, FVAL=1, LVAL=1, X = 0..H_ACTIVE-1
//   HBLANK : H_BLANK cycles, FVAL=1, LVAL=0 (between lines only)
//   FEND   : 1 cycle, FVAL=1, LVAL=0; frame counter bumps on exit
//   then VBLANK again, or IDLE when iEND was high during FEND.
//
// Patterns (arithmetic mod 2^DATA_W, max = all ones):
//   mode 0 : x + y + frame_count[7:0]
//   mode 1 : captured iLEVEL
//   mode 2 : 8x8 checker, (x[3]^y[3]) ? max : 0
//   mode 3 : Bayer-green mask, (x[0]^y[0]) ? 0 : max
//
// Build option:
//   CCD_PATTERN_LFSR_EN - when defined, mode 3 becomes LFSR noise: 16-bit
//   Fibonacci LFSR, taps 16,14,13,11, seeded 16'hACE1 on reset and at every
//   FPORCH, advanced once per ACTIVE cycle; a pixel shows the LFSR value
//   before it advances. When undefined no LFSR logic exists.
//
// Parameters:
//   DATA_W   pixel width (4..16)
//   H_ACTIVE active pixels per line (>=2)
//   V_ACTIVE active lines per frame (>=1)
//   H_BLANK  LVAL-low cycles between lines (>=1)
//   V_BLANK  FVAL-low line times between frames (>=1)
//
// Ports:
//   iCLK        in   1       pixel clock, rising edge
//   iRST        in   1       synchronous reset, active-high
//   iSTART      in   1       start continuous frames (sampled in IDLE only)
//   iEND        in   1       stop request, level, sampled during FEND
//   iMODE       in   2       pattern select, captured at FVAL rise
//   iLEVEL      in   DATA_W  solid level for mode 1, captured at FVAL rise
//   oDATA       out  DATA_W  pixel data, 0 whenever oLVAL=0
//   oFVAL       out  1       frame valid
//   oLVAL       out  1       line valid
//   oX_Cont     out  16      column of the current oDATA pixel
//   oY_Cont     out  16      row of the current oDATA pixel
//   oFrame_Cont out  32      completed frames, wraps at 2^32
//   oBUSY       out  1       high in every state except IDLE
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module ccd_pattern_gen #(
  parameter int DATA_W   = 12,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSTART,
  input  logic              iEND,
  input  logic [1:0]        iMODE,
  input  logic [DATA_W-1:0] iLEVEL,
  output logic [DATA_W-1:0] oDATA,
  output logic              oFVAL,
  output logic              oLVAL,
  output logic [15:0]       oX_Cont,
  output logic [15:0]       oY_Cont,
  output logic [31:0]       oFrame_Cont,
  output logic              oBUSY
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int VB_CYCLES = V_BLANK * (H_ACTIVE + H_BLANK);
  // One shared blanking counter serves both VBLANK and HBLANK.
  localparam int CNT_MAX   = (VB_CYCLES > H_BLANK) ? VB_CYCLES : H_BLANK;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  VB_LAST = CNT_W'(VB_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HB_LAST = CNT_W'(H_BLANK - 1);
  localparam logic [15:0]       X_LAST  = 16'(H_ACTIVE - 1);
  localparam logic [15:0]       Y_LAST  = 16'(V_ACTIVE - 1);
  localparam logic [DATA_W-1:0] PIX_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VBLANK,
    S_FPORCH,
    S_ACTIVE,
    S_HBLANK,
    S_FEND
  } state_t;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [15:0]         r_x;
  logic [15:0]         r_y;
  logic [31:0]         r_frame;
  logic [1:0]          r_mode;
  logic [DATA_W-1:0]   r_level;
  logic [DATA_W-1:0]   r_data;
  logic                r_fval;
  logic                r_lval;
  logic                r_busy;

  // Next-state values
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [15:0]         w_x_nxt;
  logic [15:0]         w_y_nxt;
  logic [31:0]         w_frame_nxt;
  logic [1:0]          w_mode_nxt;
  logic [DATA_W-1:0]   w_level_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic                w_fval_nxt;
  logic                w_lval_nxt;
  logic                w_busy_nxt;

  // Pattern datapath
  logic [15:0]         w_ramp;
  logic [DATA_W-1:0]   w_pix;

  // ---------------------------------------------------------------------------
  // Next-state / counter logic
  //
  // Every output register is loaded with the value that belongs to the state
  // being entered, so the outputs line up with r_state cycle for cycle while
  // still coming straight from flops.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_frame_nxt = r_frame;
    w_mode_nxt  = r_mode;
    w_level_nxt = r_level;

    case (r_state)
      S_IDLE: begin
        if (iSTART) begin
          w_state_nxt = S_VBLANK;
          w_cnt_nxt   = '0;
        end
      end

      S_VBLANK: begin
        if (r_cnt == VB_LAST) begin
          // FVAL rises on this edge: restart the raster and capture the
          // pattern controls for the whole frame.
          w_state_nxt = S_FPORCH;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_mode_nxt  = iMODE;
          w_level_nxt = iLEVEL;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_FPORCH: begin
        w_state_nxt = S_ACTIVE;
      end

      S_ACTIVE: begin
        if (r_x == X_LAST) begin
          if (r_y == Y_LAST) begin
            w_state_nxt = S_FEND;
          end else begin
            w_state_nxt = S_HBLANK;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_x_nxt = r_x + 16'd1;
        end
      end

      S_HBLANK: begin
        // X/Y keep the last pixel's coordinates during the gap; the row
        // advances as the next line starts.
        if (r_cnt == HB_LAST) begin
          w_state_nxt = S_ACTIVE;
          w_x_nxt     = '0;
          w_y_nxt     = r_y + 16'd1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_FEND: begin
        // A stop request only takes effect here, so a frame is never cut.
        w_frame_nxt = r_frame + 32'd1;
        w_cnt_nxt   = '0;
        w_state_nxt = iEND ? S_IDLE : S_VBLANK;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pattern generation for the pixel about to be presented
  // ---------------------------------------------------------------------------
`ifdef CCD_PATTERN_LFSR_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_nxt;
  logic        w_lfsr_fb;

  // Taps 16,14,13,11 in 1-based notation.
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_comb begin
    w_lfsr_nxt = r_lfsr;
    if ((r_state == S_VBLANK) && (w_state_nxt == S_FPORCH)) begin
      // Reseed per frame so every frame carries the same noise sequence.
      w_lfsr_nxt = LFSR_SEED;
    end else if (w_state_nxt == S_ACTIVE) begin
      w_lfsr_nxt = {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= w_lfsr_nxt;
    end
  end
`endif

  // 16-bit wrap keeps the low DATA_W bits exact, which is all mode 0 needs.
  assign w_ramp = w_x_nxt + w_y_nxt + {8'd0, r_frame[7:0]};

  always_comb begin
    w_pix = '0;
    case (w_mode_nxt)
      2'd0: w_pix = w_ramp[DATA_W-1:0];
      2'd1: w_pix = w_level_nxt;
      2'd2: w_pix = (w_x_nxt[3] ^ w_y_nxt[3]) ? PIX_MAX : '0;
`ifdef CCD_PATTERN_LFSR_EN
      // Pixel shows the register before the advance loaded on this edge.
      2'd3: w_pix = r_lfsr[DATA_W-1:0];
`else
      2'd3: w_pix = (w_x_nxt[0] ^ w_y_nxt[0]) ? '0 : PIX_MAX;
`endif
      default: w_pix = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode for the state being entered
  // ---------------------------------------------------------------------------
  always_comb begin
    w_lval_nxt = (w_state_nxt == S_ACTIVE);
    w_fval_nxt = (w_state_nxt inside {S_FPORCH, S_ACTIVE, S_HBLANK, S_FEND});
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_data_nxt = w_lval_nxt ? w_pix : '0;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (iRST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_frame <= '0;
      r_mode  <= '0;
      r_level <= '0;
      r_data  <= '0;
      r_fval  <= 1'b0;
      r_lval  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_frame <= w_frame_nxt;
      r_mode  <= w_mode_nxt;
      r_level <= w_level_nxt;
      r_data  <= w_data_nxt;
      r_fval  <= w_fval_nxt;
      r_lval  <= w_lval_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign oDATA       = r_data;
  assign oFVAL       = r_fval;
  assign oLVAL       = r_lval;
  assign oX_Cont     = r_x;
  assign oY_Cont     = r_y;
  assign oFrame_Cont = r_frame;
  assign oBUSY       = r_busy;

endmodule

// File: tb/tb_ccd_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_ccd_pattern_gen
//
// Self-checking bench for ccd_pattern_gen with a small raster
// (H_ACTIVE=8, V_ACTIVE=4, H_BLANK=3, V_BLANK=1, DATA_W=12). The expected
// waveform of each frame is a timeline derived from the frame rules, and the
// expected pixels come from an arithmetic pattern model (plus a precomputed
// LFSR sequence when CCD_PATTERN_LFSR_EN is defined). Pattern modes, levels,
// mid-frame control changes, stop rows and the reset point are randomized.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ccd_pattern_gen;

  localparam int DW     = 12;
  localparam int H      = 8;
  localparam int V      = 4;
  localparam int HB     = 3;
  localparam int VB     = 1;
  localparam int VB_CYC = VB * (H + HB);
  localparam int MAXV   = (1 << DW) - 1;

  logic          iCLK;
  logic          iRST;
  logic          iSTART;
  logic          iEND;
  logic [1:0]    iMODE;
  logic [DW-1:0] iLEVEL;
  logic [DW-1:0] oDATA;
  logic          oFVAL;
  logic          oLVAL;
  logic [15:0]   oX_Cont;
  logic [15:0]   oY_Cont;
  logic [31:0]   oFrame_Cont;
  logic          oBUSY;

  int n_checks;
  int n_errors;
  int exp_frames;   // frames the model says have completed

`ifdef CCD_PATTERN_LFSR_EN
  logic [DW-1:0] lfsr_seq [V*H];
`endif

  ccd_pattern_gen #(
    .DATA_W   (DW),
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .H_BLANK  (HB),
    .V_BLANK  (VB)
  ) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iSTART      (iSTART),
    .iEND        (iEND),
    .iMODE       (iMODE),
    .iLEVEL      (iLEVEL),
    .oDATA       (oDATA),
    .oFVAL       (oFVAL),
    .oLVAL       (oLVAL),
    .oX_Cont     (oX_Cont),
    .oY_Cont     (oY_Cont),
    .oFrame_Cont (oFrame_Cont),
    .oBUSY       (oBUSY)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pattern model, written from the pattern rules with plain arithmetic.
  function automatic logic [DW-1:0] exp_pixel(input int mode, input int level,
                                               input int x, input int y, input int frame);
    int v;
    case (mode)
      0:       v = (x + y + (frame % 256)) % (1 << DW);
      1:       v = level;
      2:       v = (((x / 8) % 2) != ((y / 8) % 2)) ? MAXV : 0;
`ifdef CCD_PATTERN_LFSR_EN
      default: v = int'(lfsr_seq[y*H + x]);
`else
      default: v = ((x % 2) != (y % 2)) ? 0 : MAXV;
`endif
    endcase
    return DW'(v);
  endfunction

  // Walks one frame cycle by cycle against the expected timeline.
  // Entry: the next falling edge shows VBLANK cycle number vb_seen.
  // Exit : the last sample taken is the first cycle after FEND.
  // end_row/chg_row = -1 disables the stop request / control change.
  task automatic walk_frame(input int vb_seen, input int end_row, input int chg_row,
                            input logic [1:0] chg_mode, input logic [DW-1:0] chg_level);
    int   lat_mode;
    int   lat_level;
    logic ended;
    for (int i = vb_seen; i < VB_CYC; i++) begin
      @(negedge iCLK);
      iSTART = 1'b0;
      check("vblank", 64'({oBUSY, oFVAL, oLVAL, oDATA}), 64'({3'b100, {DW{1'b0}}}));
    end
    // FPORCH: controls were captured at the edge that raised FVAL.
    @(negedge iCLK);
    lat_mode  = int'(iMODE);
    lat_level = int'(iLEVEL);
    check("fporch", 64'({oBUSY, oFVAL, oLVAL, oDATA}), 64'({3'b110, {DW{1'b0}}}));
    check("fporch_xy", 64'({oX_Cont, oY_Cont}), 64'd0);
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        @(negedge iCLK);
        check("act_sync", 64'({oBUSY, oFVAL, oLVAL}), 64'(3'b111));
        check("act_xy", 64'({oX_Cont, oY_Cont}), 64'({16'(c), 16'(r)}));
        check("act_pix", 64'(oDATA),
              64'(exp_pixel(lat_mode, lat_level, c, r, exp_frames)));
        if (c == 0 && r == end_row) iEND = 1'b1;
        if (c == 0 && r == chg_row) begin
          iMODE  = chg_mode;
          iLEVEL = chg_level;
        end
      end
      if (r < V - 1) begin
        for (int b = 0; b < HB; b++) begin
          @(negedge iCLK);
          check("hblank", 64'({oBUSY, oFVAL, oLVAL, oDATA}), 64'({3'b110, {DW{1'b0}}}));
        end
      end
    end
    @(negedge iCLK);
    check("fend", 64'({oBUSY, oFVAL, oLVAL, oDATA}), 64'({3'b110, {DW{1'b0}}}));
    ended = iEND;
    @(negedge iCLK);
    exp_frames++;
    check("frame_cnt", 64'(oFrame_Cont), 64'(exp_frames));
    check("post_fend", 64'({oBUSY, oFVAL, oLVAL, oDATA}), 64'({~ended, 2'b00, {DW{1'b0}}}));
    iEND = 1'b0;
  endtask

  // Counts cycles with any activity over a window; expected to be zero.
  task automatic expect_idle(input string tag, input int cycles);
    int busy_cnt;
    busy_cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge iCLK);
      if (oBUSY || oFVAL || oLVAL) busy_cnt++;
    end
    check(tag, 64'(busy_cnt), 64'd0);
  endtask

  initial begin
    int waited;
    int end_row;
    logic [1:0] nm;
`ifdef CCD_PATTERN_LFSR_EN
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < V*H; i++) begin
      lfsr_seq[i] = l[DW-1:0];
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
`endif
    n_checks   = 0;
    n_errors   = 0;
    exp_frames = 0;
    iRST   = 1'b1;
    iSTART = 1'b0;
    iEND   = 1'b0;
    iMODE  = 2'd0;
    iLEVEL = '0;

    // Reset state
    repeat (3) @(negedge iCLK);
    check("rst_ctl", 64'({oBUSY, oFVAL, oLVAL, oDATA}), 64'd0);
    check("rst_cnt", 64'({oX_Cont, oY_Cont, oFrame_Cont}), 64'd0);
    iRST = 1'b0;
    expect_idle("idle_no_start", 6);

    // Ramp frame 0, then a mid-frame switch to solid 12'h5A5, then a stop
    // request on row 1 of the solid frame.
    iMODE  = 2'd0;
    iLEVEL = DW'($urandom);
    iSTART = 1'b1;
    walk_frame(0, -1, 2, 2'd1, 12'h5A5);
    walk_frame(1, 1, -1, 2'd0, '0);
    expect_idle("idle_after_end", 20);

    // Ramp with nonzero frame count; mode change to checker during row 2.
    iMODE  = 2'd0;
    iSTART = 1'b1;
    walk_frame(0, -1, 2, 2'd2, DW'($urandom));
    walk_frame(1, 3, -1, 2'd0, '0);
    expect_idle("idle_after_chk", 5);

    // Randomized run; frames 2 and 3 are forced to mode 3.
    iMODE  = 2'($urandom_range(3, 0));
    iLEVEL = DW'($urandom);
    iSTART = 1'b1;
    for (int k = 0; k < 6; k++) begin
      nm      = (k == 1 || k == 2) ? 2'd3 : 2'($urandom_range(3, 0));
      end_row = (k == 5) ? int'($urandom_range(V - 1, 0)) : -1;
      walk_frame((k == 0) ? 0 : 1, end_row, int'($urandom_range(V - 1, 0)), nm, DW'($urandom));
    end
    expect_idle("idle_after_rand", 5);

    // Reset in the middle of an active line.
    iMODE  = 2'd0;
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    waited = 0;
    while (!oLVAL && waited < 200) begin
      @(negedge iCLK);
      waited++;
    end
    check("lval_seen", 64'(oLVAL), 64'd1);
    repeat ($urandom_range(H - 2, 0)) @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
    exp_frames = 0;
    check("rst_mid_ctl", 64'({oBUSY, oFVAL, oLVAL, oDATA}), 64'd0);
    check("rst_mid_cnt", 64'({oX_Cont, oY_Cont, oFrame_Cont}), 64'd0);
    iRST = 1'b0;
    expect_idle("idle_after_rst", 100);

    // Fresh start after reset: ramp restarts from frame count 0.
    iMODE  = 2'd0;
    iSTART = 1'b1;
    walk_frame(0, 0, -1, 2'd0, '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
